// File: rtl/issue_ctrl.sv
// Issue controller between the decode stage and the EXU.
//
// Keeps a 32-entry register scoreboard and stalls issue on RAW/WAW hazards.
// Also stalls when the maximum number of writebacks is outstanding, and while
// a control-flow instruction waits for the EXU to resolve it.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   id_valid/id_ready  decode-side handshake (id_ready = instruction consumed)
//   rs1id, rs2id       source register indices (0 = unused)
//   rdid, rdwen        destination register index and write enable
//   brch, jal, jalr    control-flow instruction flags
//   ex_valid/ex_ready  EXU-side handshake
//   wb_valid, wb_rdid  writeback retiring one pending register write
//   redirect_valid     EXU has resolved the outstanding control-flow instruction
//   busy_vec           scoreboard, bit i = write to xi pending
//   pend_cnt           number of pending writebacks
//   cf_wait            high while waiting for a control-flow resolution
//   sb_err             one-cycle pulse after a writeback to a non-busy register
module issue_ctrl #(
  parameter int unsigned REG_ADDRW = 5,
  parameter int unsigned MAX_PEND  = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [REG_ADDRW-1:0] rs1id,
  input  logic [REG_ADDRW-1:0] rs2id,
  input  logic [REG_ADDRW-1:0] rdid,
  input  logic                 rdwen,
  input  logic                 brch,
  input  logic                 jal,
  input  logic                 jalr,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  input  logic                 wb_valid,
  input  logic [REG_ADDRW-1:0] wb_rdid,
  input  logic                 redirect_valid,
  output logic [31:0]          busy_vec,
  output logic [CNT_W-1:0]     pend_cnt,
  output logic                 cf_wait,
  output logic                 sb_err
);

  typedef enum logic [0:0] {
    StRun,
    StCfWait
  } state_e;

  localparam logic [CNT_W-1:0] MaxPendCnt = CNT_W'(MAX_PEND);

  state_e           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             sb_err_q, sb_err_d;

  logic haz;
  logic full;
  logic fire;
  logic is_cf;
  logic sb_set;
  logic sb_clr;
  logic wb_nz;

  // Hazard check looks only at the registered scoreboard; a writeback in this
  // cycle unblocks dependents from the next cycle on. busy_q[0] is always 0.
  assign haz  = busy_q[rs1id] | busy_q[rs2id] | (rdwen & busy_q[rdid]);
  assign full = (pend_cnt_q == MaxPendCnt) & rdwen & (rdid != '0);

  // ex_valid is gated by reset directly so it is low for the whole reset
  // window, not just after the first clock edge.
  assign ex_valid = i_rst_n & (state_q == StRun) & id_valid & ~haz & ~full;
  assign fire     = ex_valid & ex_ready;
  assign id_ready = fire;

  assign is_cf  = brch | jal | jalr;
  assign wb_nz  = wb_valid & (wb_rdid != '0);
  assign sb_set = fire & rdwen & (rdid != '0);
  assign sb_clr = wb_nz & busy_q[wb_rdid];

  // Scoreboard and pending-count next state. A set and a clear in the same
  // cycle never hit the same register: the WAW check stalls that issue.
  always_comb begin
    busy_d     = busy_q;
    pend_cnt_d = pend_cnt_q;
    sb_err_d   = wb_nz & ~busy_q[wb_rdid];

    if (sb_set) begin
      busy_d[rdid] = 1'b1;
    end
    if (sb_clr) begin
      busy_d[wb_rdid] = 1'b0;
    end
    busy_d[0] = 1'b0;

    case ({sb_set, sb_clr})
      2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
      2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  // Control-flow FSM. redirect_valid only matters while waiting; a redirect
  // seen in RUN (including the fire cycle of the branch) is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (fire && is_cf) begin
          state_d = StCfWait;
        end
      end
      StCfWait: begin
        if (redirect_valid) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StRun;
      busy_q     <= '0;
      pend_cnt_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = pend_cnt_q;
  assign cf_wait  = (state_q == StCfWait);
  assign sb_err   = sb_err_q;

endmodule
